rd_ptr: RTL and testbench
=========================

// Module: rd_ptr
// PURPOSE
//   Read-side pointer/flag logic of a synchronous FIFO in front of a dual-port RAM.
//   - Keeps an (ALEN+1)-bit binary read pointer; the extra MSB is the wrap bit.
//   - Compares it with the write pointer, which is in the same clock domain.
//   - Drives the RAM read address and read-enable.
//   - Flags empty.
//   - Pairs with the write-pointer block. No clock-domain crossing, no gray code.
// PARAMETERS
//   ALEN  8  RAM address width; FIFO depth is 2**ALEN entries.
//   INCR  1  Pointer advance per accepted read. Must be a power of two <= 2**ALEN.
// PORTS
//   clk        in   1       single clock, rising edge
//   rstn       in   1       reset, asynchronous, active-low
//   i_ren      in   1       read request from consumer
//   i_wptr     in   ALEN+1  write pointer from write-side block (same clock)
//   o_raddr    out  ALEN    RAM read address
//   o_rptr     out  ALEN+1  read pointer, including wrap bit
//   o_rempty   out  1       FIFO empty
//   o_ram_ren  out  1       qualified RAM read enable
// BEHAVIOUR
//   - Reset (rstn=0, asynchronous): rptr=0.
//     - Hence o_raddr=0 and o_rptr=0.
//     - o_rempty and o_ram_ren then follow the combinational equations below
//       (o_rempty=1 when i_wptr=0).
//   - o_rempty = (o_rptr == i_wptr), full (ALEN+1)-bit compare, combinational.
//   - o_ram_ren = i_ren & ~o_rempty, combinational.
//     - A read request while empty is ignored: no pointer move, no RAM read.
//   - On rising clk with rstn=1 and o_ram_ren=1: rptr <= rptr + INCR, modulo 2**(ALEN+1).
//     - Otherwise rptr holds.
//   - o_raddr = rptr[ALEN-1:0]. Zero latency from the pointer register.
//   - RAM data for the address is the RAM's concern; this block adds no extra pipeline stage.
//   - Wrap-around: rptr 0x1FF + 1 -> 0x000 for ALEN=8.
//     - The MSB toggles on each pass through the RAM.
//   - Full FIFO (i_wptr = rptr ^ (1<<ALEN)) is not empty: reads proceed.
//   - Read and write in the same cycle: the block uses the current i_wptr only.
//     - A write landing this cycle is visible next cycle.
//   - i_wptr changing mid-stream is re-evaluated every cycle.
//   - Reset asserted mid-operation forces rptr=0 immediately.
//   - Outputs are never X after reset. i_ren=X must not corrupt rptr while empty.
// STRUCTURE
//   - Shared package fifo_pkg:
//     - localparam PTR_W = ALEN+1.
//     - typedefs addr_t = logic [ALEN-1:0] and ptr_t = logic [ALEN:0].
//     - Function ptr_empty(ptr_t r, ptr_t w).
//     - Function ptr_full(ptr_t r, ptr_t w), reused by the write-side block.
//   - One natural sub-module, ptr_cnt: generic enable-gated (ALEN+1)-bit modulo counter
//     with step INCR and async active-low clear; shared with the write pointer.
//   - rd_ptr = ptr_cnt + empty compare + enable gating.
// TESTING
//   1. Reset, i_wptr=0, i_ren=1 for 256 cycles:
//      -> rptr stays 0x000, o_rempty=1, o_ram_ren=0 throughout.
//   2. i_wptr=0x100 (full), i_ren=1 for 257 cycles:
//      -> o_ram_ren=1 for exactly 256 cycles; o_raddr steps 0x00..0xFF;
//         rptr ends 0x100; o_rempty=1 and o_ram_ren=0 on cycle 257.
//   3. Continue from 2, i_wptr=0x005, read to empty:
//      -> o_raddr wraps 0xFF->0x00; rptr reaches 0x005; o_rempty=1.
//   4. i_ren toggles 1/0 with data present:
//      -> rptr advances only on cycles where i_ren=1; no double counting.
//   5. Assert rstn=0 mid-read (rptr=0x080):
//      -> o_rptr=0 immediately without a clock edge; o_rempty reflects i_wptr.
//   6. INCR=2 build, i_wptr=0x010, 8 reads:
//      -> o_raddr sequence 0,2,4..0x0E; o_rempty=1 after the 8th read.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer types and pointer-compare helpers for the read and write pointer blocks.
`default_nettype none

package fifo_pkg;

    localparam int FIFO_ALEN = 8;
    localparam int PTR_W     = FIFO_ALEN + 1;

    typedef logic [FIFO_ALEN-1:0] addr_t;
    typedef logic [FIFO_ALEN:0]   ptr_t;

    function automatic logic ptr_empty(input ptr_t r, input ptr_t w);
        return (r == w);
    endfunction

    // Full when addresses match but the wrap bits differ.
    function automatic logic ptr_full(input ptr_t r, input ptr_t w);
        return ((r ^ w) == {1'b1, {FIFO_ALEN{1'b0}}});
    endfunction

endpackage

`default_nettype wire

// File: rtl/rd_ptr_cnt.sv
// Enable-gated modulo-2**W counter with a fixed step and asynchronous active-low clear.
`default_nettype none

module ptr_cnt #(
    parameter int W    = 9,
    parameter int INCR = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] STEP = W'(INCR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + STEP;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rd_ptr.sv
// FIFO read-side pointer: binary read pointer with wrap bit, empty flag and RAM read enable.
`default_nettype none

module rd_ptr
    import fifo_pkg::*;
#(
    parameter int ALEN = FIFO_ALEN,
    parameter int INCR = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_ren,
    input  logic [ALEN:0]   i_wptr,
    output logic [ALEN-1:0] o_raddr,
    output logic [ALEN:0]   o_rptr,
    output logic            o_rempty,
    output logic            o_ram_ren
);

    logic [ALEN:0] rptr;
    logic          empty;
    logic          ram_ren;

    ptr_cnt #(
        .W    (ALEN + 1),
        .INCR (INCR)
    ) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (ram_ren),
        .cnt  (rptr)
    );

    // The package helper is typed for the default width; other widths compare directly.
    generate
        if (ALEN == FIFO_ALEN) begin : g_pkg_cmp
            assign empty = ptr_empty(rptr, i_wptr);
        end else begin : g_local_cmp
            assign empty = (rptr == i_wptr);
        end
    endgenerate

    // Empty forces the enable low even if the request is unknown.
    assign ram_ren   = i_ren & ~empty;

    assign o_rptr    = rptr;
    assign o_raddr   = rptr[ALEN-1:0];
    assign o_rempty  = empty;
    assign o_ram_ren = ram_ren;

endmodule

`default_nettype wire

// File: tb/tb_rd_ptr.sv
// Self-checking bench for rd_ptr: directed scenarios plus randomized traffic against a pointer model.
`default_nettype none

module tb_rd_ptr;

    logic       clk = 1'b0;
    logic       rstn, ren;
    logic [8:0] wptr;
    logic [7:0] raddr;
    logic [8:0] rptr;
    logic       rempty, ram_ren;

    logic       rstn2, ren2;
    logic [8:0] wptr2;
    logic [7:0] raddr2;
    logic [8:0] rptr2;
    logic       rempty2, ram_ren2;

    int          total = 0;
    int          bad   = 0;
    int unsigned m_r   = 0;

    always #5 clk = ~clk;

    rd_ptr #(.ALEN(8), .INCR(1)) dut (
        .clk(clk), .rstn(rstn), .i_ren(ren), .i_wptr(wptr),
        .o_raddr(raddr), .o_rptr(rptr), .o_rempty(rempty), .o_ram_ren(ram_ren)
    );

    rd_ptr #(.ALEN(8), .INCR(2)) dut2 (
        .clk(clk), .rstn(rstn2), .i_ren(ren2), .i_wptr(wptr2),
        .o_raddr(raddr2), .o_rptr(rptr2), .o_rempty(rempty2), .o_ram_ren(ram_ren2)
    );

    // Model: a read is accepted when requested and the pointers differ; pointer steps mod 512.
    task automatic tick();
        if (ren === 1'b1 && m_r != int'(wptr)) m_r = (m_r + 1) % 512;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; ren = 1'b0; wptr = 9'h000;
        rstn2 = 1'b0; ren2 = 1'b0; wptr2 = 9'h000;
        #3;
        total++; if (rptr !== 9'h000) begin bad++; $display("FAIL reset_rptr got=%h exp=000", rptr); end
        total++; if (raddr !== 8'h00) begin bad++; $display("FAIL reset_raddr got=%h exp=00", raddr); end
        total++; if (rempty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", rempty); end
        total++; if (ram_ren !== 1'b0) begin bad++; $display("FAIL reset_ram_ren got=%b exp=0", ram_ren); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_r = 0;
    endtask

    task automatic test_empty_reads();
        wptr = 9'h000;
        for (int i = 0; i < 256; i++) begin
            ren = (i % 4 == 3) ? 1'bx : 1'b1;
            #1;
            total++;
            if (rptr !== 9'h000 || rempty !== 1'b1 || ram_ren !== 1'b0) begin
                bad++;
                $display("FAIL empty_read cyc=%0d got rptr=%h empty=%b ren=%b exp 000/1/0", i, rptr, rempty, ram_ren);
            end
            tick();
        end
        ren = 1'b0;
    endtask

    task automatic test_full_drain();
        int  n_ren = 0;
        logic exp_empty;
        wptr = 9'h100;
        ren  = 1'b1;
        for (int i = 0; i < 257; i++) begin
            #1;
            exp_empty = (m_r == int'(wptr));
            total++;
            if (raddr !== 8'(m_r) || rempty !== exp_empty || ram_ren !== !exp_empty) begin
                bad++;
                $display("FAIL full_drain cyc=%0d got addr=%h empty=%b ren=%b exp %h/%b/%b",
                         i, raddr, rempty, ram_ren, 8'(m_r), exp_empty, !exp_empty);
            end
            if (ram_ren === 1'b1) n_ren++;
            tick();
        end
        total++; if (n_ren != 256) begin bad++; $display("FAIL full_drain_count got=%0d exp=256", n_ren); end
        total++; if (rptr !== 9'h100) begin bad++; $display("FAIL full_drain_end got=%h exp=100", rptr); end
        ren = 1'b0;
    endtask

    task automatic test_wrap_to_empty();
        int         cyc = 0;
        bit         saw_wrap = 0;
        logic [7:0] prev;
        wptr = 9'h005;
        ren  = 1'b1;
        #1;
        while (rempty !== 1'b1 && cyc < 600) begin
            prev = raddr;
            tick();
            cyc++;
            if (prev == 8'hFF && raddr == 8'h00) saw_wrap = 1;
            total++;
            if (rptr !== 9'(m_r)) begin bad++; $display("FAIL wrap_step got=%h exp=%h", rptr, 9'(m_r)); end
        end
        total++; if (cyc >= 600) begin bad++; $display("FAIL wrap_timeout got=%0d cycles exp<600", cyc); end
        total++; if (!saw_wrap) begin bad++; $display("FAIL wrap_addr got=no_wrap exp=FF_to_00"); end
        total++; if (rptr !== 9'h005 || rempty !== 1'b1) begin
            bad++; $display("FAIL wrap_end got rptr=%h empty=%b exp 005/1", rptr, rempty);
        end
        ren = 1'b0;
    endtask

    task automatic test_toggle();
        int unsigned start = m_r;
        int          ones  = 0;
        wptr = 9'((m_r + 40) % 512);
        for (int i = 0; i < 20; i++) begin
            ren = (i % 2 == 0);
            if (ren) ones++;
            #1;
            total++;
            if (rptr !== 9'(m_r)) begin bad++; $display("FAIL toggle cyc=%0d got=%h exp=%h", i, rptr, 9'(m_r)); end
            tick();
        end
        total++;
        if (rptr !== 9'((start + ones) % 512)) begin
            bad++; $display("FAIL toggle_end got=%h exp=%h", rptr, 9'((start + ones) % 512));
        end
        ren = 1'b0;
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        wptr = 9'h0C0;
        ren  = 1'b1;
        while (m_r != 32'h80 && cyc < 600) begin
            tick();
            cyc++;
        end
        total++; if (rptr !== 9'h080) begin bad++; $display("FAIL arst_pre got=%h exp=080", rptr); end
        #2;
        rstn = 1'b0;
        #1;
        total++; if (rptr !== 9'h000 || raddr !== 8'h00) begin
            bad++; $display("FAIL arst_ptr got rptr=%h addr=%h exp 000/00", rptr, raddr);
        end
        total++; if (rempty !== 1'b0) begin bad++; $display("FAIL arst_empty_c0 got=%b exp=0", rempty); end
        wptr = 9'h000;
        #1;
        total++; if (rempty !== 1'b1 || ram_ren !== 1'b0) begin
            bad++; $display("FAIL arst_empty_00 got empty=%b ren=%b exp 1/0", rempty, ram_ren);
        end
        ren = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_r  = 0;
    endtask

    task automatic test_incr2();
        wptr2 = 9'h010;
        ren2  = 1'b1;
        rstn2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++;
            if (raddr2 !== 8'(2 * i) || rempty2 !== 1'b0 || ram_ren2 !== 1'b1) begin
                bad++;
                $display("FAIL incr2 rd=%0d got addr=%h empty=%b ren=%b exp %h/0/1", i, raddr2, rempty2, ram_ren2, 8'(2 * i));
            end
            @(posedge clk);
            #1;
        end
        total++; if (rempty2 !== 1'b1 || rptr2 !== 9'h010 || ram_ren2 !== 1'b0) begin
            bad++; $display("FAIL incr2_end got empty=%b rptr=%h ren=%b exp 1/010/0", rempty2, rptr2, ram_ren2);
        end
        ren2 = 1'b0;
    endtask

    task automatic test_random();
        logic exp_empty;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) wptr = 9'((m_r + $urandom_range(0, 256)) % 512);
            ren = 1'($urandom_range(0, 1));
            #1;
            exp_empty = (m_r == int'(wptr));
            total++;
            if (rptr !== 9'(m_r) || raddr !== 8'(m_r) || rempty !== exp_empty || ram_ren !== (ren & !exp_empty)) begin
                bad++;
                $display("FAIL random cyc=%0d got rptr=%h addr=%h empty=%b ren=%b exp %h/%h/%b/%b",
                         i, rptr, raddr, rempty, ram_ren, 9'(m_r), 8'(m_r), exp_empty, ren & !exp_empty);
            end
            tick();
        end
        ren = 1'b0;
    endtask

    initial begin
        test_reset();
        test_empty_reads();
        test_full_drain();
        test_wrap_to_empty();
        test_toggle();
        test_async_reset();
        test_incr2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
